// File: rtl/maj_exhaustive_bist.sv
// Exhaustive BIST sequencer for an N-input threshold gate: sweeps every input
// vector, compares the gate output against a popcount reference, and logs errors.
module maj_exhaustive_bist #(
  parameter int N       = 5,
  parameter int THRESH  = 3,
  parameter int DUT_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] x,
  input  logic         y_dut,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail_vec,
  output logic         first_fail_valid
);

  localparam int PCW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [N-1:0] X_LAST     = '1;
  localparam logic [N-1:0] X_ONE      = N'(1);
  localparam logic [N:0]   ERR_ONE    = (N + 1)'(1);
  localparam logic [2:0]   DRAIN_LAST = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

  logic [1:0]     r_state;
  logic [N-1:0]   r_x;
  logic [2:0]     r_drain_cnt;
  logic [N:0]     r_err;
  logic [N-1:0]   r_ffv;
  logic           r_ffvalid;

  logic           w_accept;
  logic [PCW-1:0] w_popcount;
  logic           w_ref;
  logic           w_in_vld;
  logic           w_tap_vld;
  logic [N-1:0]   w_tap_vec;
  logic           w_tap_ref;
  logic           w_mismatch;

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < N; i++) begin
      w_popcount = w_popcount + PCW'(r_x[i]);
    end
  end

  assign w_ref    = (w_popcount >= PCW'(THRESH));
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_in_vld = (r_state == S_DRIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_drain_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_x     <= '0;
          end
        end
        S_DRIVE: begin
          // x parks on the last vector once the sweep has been issued
          if (r_x == X_LAST) begin
            r_state     <= (DUT_LAT > 0) ? S_DRAIN : S_DONE;
            r_drain_cnt <= DRAIN_LAST;
          end else begin
            r_x <= r_x + X_ONE;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == 3'd0) r_state <= S_DONE;
          else                     r_drain_cnt <= r_drain_cnt - 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Vector and its reference travel together so the compare sees the
  // gate output that corresponds to them after the gate's own latency.
  generate
    if (DUT_LAT == 0) begin : g_comb_tap
      assign w_tap_vld = w_in_vld;
      assign w_tap_vec = r_x;
      assign w_tap_ref = w_ref;
    end else begin : g_delay_tap
      logic         r_dl_vld [DUT_LAT];
      logic [N-1:0] r_dl_vec [DUT_LAT];
      logic         r_dl_ref [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst || w_accept) begin
          for (int i = 0; i < DUT_LAT; i++) r_dl_vld[i] <= 1'b0;
        end else begin
          for (int i = DUT_LAT - 1; i > 0; i--) r_dl_vld[i] <= r_dl_vld[i-1];
          r_dl_vld[0] <= w_in_vld;
        end
        for (int i = DUT_LAT - 1; i > 0; i--) begin
          r_dl_vec[i] <= r_dl_vec[i-1];
          r_dl_ref[i] <= r_dl_ref[i-1];
        end
        r_dl_vec[0] <= r_x;
        r_dl_ref[0] <= w_ref;
      end

      assign w_tap_vld = r_dl_vld[DUT_LAT-1];
      assign w_tap_vec = r_dl_vec[DUT_LAT-1];
      assign w_tap_ref = r_dl_ref[DUT_LAT-1];
    end
  endgenerate

  assign w_mismatch = w_tap_vld && (y_dut != w_tap_ref);

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_err     <= '0;
      r_ffv     <= '0;
      r_ffvalid <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= r_err + ERR_ONE;
      if (!r_ffvalid) begin
        r_ffv     <= w_tap_vec;
        r_ffvalid <= 1'b1;
      end
    end
  end

  assign x                = r_x;
  assign busy             = (r_state == S_DRIVE) || (r_state == S_DRAIN);
  assign done             = (r_state == S_DONE);
  assign pass             = done && (r_err == '0);
  assign err_count        = r_err;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvalid;

endmodule

// File: tb/tb_maj_exhaustive_bist.sv
// Bench for maj_exhaustive_bist: a combinational-gate instance (DUT_LAT=0) and a
// two-stage registered-gate instance (DUT_LAT=2), with injectable gate faults.
module tb_maj_exhaustive_bist;

  localparam int N  = 5;
  localparam int TH = 3;
  localparam int NV = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start0, start1, y0, y1;
  logic [N-1:0] x0, x1, ffv0, ffv1;
  logic         busy0, done0, pass0, ffval0;
  logic         busy1, done1, pass1, ffval1;
  logic [N:0]   err0, err1;

  int tests = 0;
  int fails = 0;

  // mode: 0 = reference xor bad mask, 2 = stuck 0, 3 = stuck 1, 5 = registered twice
  int          mode0 = 0;
  logic [31:0] bad0  = '0;
  logic [31:0] bad1  = '0;
  logic        d1, d2, e1, e2;

  maj_exhaustive_bist #(.N(N), .THRESH(TH), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .x(x0), .y_dut(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  maj_exhaustive_bist #(.N(N), .THRESH(TH), .DUT_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y_dut(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  function automatic bit maj_ref(input int v);
    return $countones(v) >= TH;
  endfunction

  function automatic bit gate_model(input int mode, input logic [31:0] bad, input int v);
    if (mode == 2) return 1'b0;
    if (mode == 3) return 1'b1;
    return maj_ref(v) ^ bad[v];
  endfunction

  function automatic int exp_err(input int mode, input logic [31:0] bad);
    int n = 0;
    for (int v = 0; v < NV; v++) if (gate_model(mode, bad, v) != maj_ref(v)) n++;
    return n;
  endfunction

  function automatic int exp_first(input int mode, input logic [31:0] bad);
    for (int v = 0; v < NV; v++) if (gate_model(mode, bad, v) != maj_ref(v)) return v;
    return -1;
  endfunction

  always_comb begin
    y0 = maj_ref(int'(x0)) ^ bad0[x0];
    case (mode0)
      2:       y0 = 1'b0;
      3:       y0 = 1'b1;
      5:       y0 = d2;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    d1 <= maj_ref(int'(x0));
    d2 <= d1;
    e1 <= maj_ref(int'(x1)) ^ bad1[x1];
    e2 <= e1;
  end
  assign y1 = e2;

  // Pulses start for one edge, then follows the sweep until done (bounded).
  task automatic run_sweep(input int which, output int busy_cycles, output int done_at,
                           output bit seq_ok);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    busy_cycles = 0;
    done_at     = -1;
    seq_ok      = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if ((which == 0) ? busy0 : busy1) busy_cycles++;
      if (c <= NV && int'((which == 0) ? x0 : x1) != c - 1) seq_ok = 1'b0;
      if ((which == 0) ? done0 : done1) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({x0, busy0, done0, pass0, err0, ffv0, ffval0} !== '0) begin
      fails++;
      $display("FAIL reset_dut0: got x=%0d busy=%b done=%b pass=%b err=%0d ffv=%0d ffval=%b required all 0",
               x0, busy0, done0, pass0, err0, ffv0, ffval0);
    end
    tests++;
    if ({x1, busy1, done1, pass1, err1, ffv1, ffval1} !== '0) begin
      fails++;
      $display("FAIL reset_dut1: got x=%0d busy=%b done=%b err=%0d required all 0", x1, busy1, done1, err1);
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tests++;
    if (busy0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: busy=%b required 0", busy0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_sweep;
    int bc, da; bit sq;
    mode0 = 0; bad0 = '0;
    run_sweep(0, bc, da, sq);
    tests++;
    if (!sq) begin fails++; $display("FAIL clean_x_sequence: x did not step 0..31 (got 0, required 1)"); end
    tests++;
    if (da != 33) begin fails++; $display("FAIL clean_done_at: got %0d required 33", da); end
    tests++;
    if (bc != 32) begin fails++; $display("FAIL clean_busy_cycles: got %0d required 32", bc); end
    tests++;
    if ({pass0, err0, ffval0} !== {1'b1, 6'd0, 1'b0}) begin
      fails++;
      $display("FAIL clean_result: got pass=%b err=%0d ffval=%b required 1 0 0", pass0, err0, ffval0);
    end
    tests++;
    if (x0 !== 5'd31) begin fails++; $display("FAIL clean_x_hold: got %0d required 31", x0); end
  endtask

  task automatic test_single_fault;
    int bc, da; bit sq;
    mode0 = 0; bad0 = 32'h0000_0080;
    run_sweep(0, bc, da, sq);
    tests++;
    if ({err0, ffv0, ffval0, pass0} !== {6'd1, 5'b00111, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL single_fault: got err=%0d ffv=%0d ffval=%b pass=%b required 1 7 1 0",
               err0, ffv0, ffval0, pass0);
    end
  endtask

  task automatic test_stuck;
    int bc, da; bit sq;
    for (int m = 2; m <= 3; m++) begin
      mode0 = m; bad0 = '0;
      run_sweep(0, bc, da, sq);
      tests++;
      if (int'(err0) != exp_err(m, bad0)) begin
        fails++; $display("FAIL stuck%0d_err: got %0d required %0d", m - 2, err0, exp_err(m, bad0));
      end
      tests++;
      if (int'(ffv0) != exp_first(m, bad0) || ffval0 !== 1'b1) begin
        fails++;
        $display("FAIL stuck%0d_first: got %0d valid=%b required %0d", m - 2, ffv0, ffval0, exp_first(m, bad0));
      end
    end
    mode0 = 0;
  endtask

  task automatic test_random_faults;
    int bc, da, ee, ef; bit sq;
    for (int it = 0; it < 5; it++) begin
      mode0 = 0;
      bad0 = (it == 4) ? '0 : ($urandom & $urandom & ((it[0]) ? $urandom : 32'hFFFF_FFFF));
      ee = exp_err(0, bad0);
      ef = exp_first(0, bad0);
      run_sweep(0, bc, da, sq);
      $display("[TB] random sweep %0d mask=%h err=%0d expected=%0d", it, bad0, err0, ee);
      tests++;
      if (int'(err0) != ee || pass0 !== (ee == 0)) begin
        fails++; $display("FAIL rand%0d_err: got err=%0d pass=%b required %0d", it, err0, pass0, ee);
      end
      tests++;
      if (ffval0 !== (ef >= 0) || (ef >= 0 && int'(ffv0) != ef)) begin
        fails++; $display("FAIL rand%0d_first: got ffv=%0d valid=%b required %0d", it, ffv0, ffval0, ef);
      end
    end
    bad0 = '0;
  endtask

  task automatic test_latency;
    int bc, da, ee, ef; bit sq;
    bad1 = '0;
    run_sweep(1, bc, da, sq);
    tests++;
    if (da != 35 || bc != 34 || !sq) begin
      fails++; $display("FAIL lat2_timing: got done_at=%0d busy=%0d seq=%b required 35 34 1", da, bc, sq);
    end
    tests++;
    if ({pass1, err1, ffval1} !== {1'b1, 6'd0, 1'b0}) begin
      fails++; $display("FAIL lat2_clean: got pass=%b err=%0d ffval=%b required 1 0 0", pass1, err1, ffval1);
    end
    bad1 = $urandom & $urandom;
    ee = exp_err(0, bad1);
    ef = exp_first(0, bad1);
    run_sweep(1, bc, da, sq);
    tests++;
    if (int'(err1) != ee || (ef >= 0 && int'(ffv1) != ef) || ffval1 !== (ef >= 0)) begin
      fails++;
      $display("FAIL lat2_faults: got err=%0d ffv=%0d ffval=%b required %0d %0d", err1, ffv1, ffval1, ee, ef);
    end
    bad1 = '0;
    mode0 = 5;
    run_sweep(0, bc, da, sq);
    tests++;
    if (!(err0 > 0) || pass0 !== 1'b0) begin
      fails++; $display("FAIL lat_misaligned: got err=%0d pass=%b required err>0 pass=0", err0, pass0);
    end
    mode0 = 0;
  endtask

  task automatic test_reset_mid;
    int bc, da; bit sq, seen;
    mode0 = 2;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (x0 == 5'd10) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL reset_mid_wait: x never reached 10 (got %0d)", x0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({x0, busy0, done0, pass0, err0, ffv0, ffval0} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got x=%0d busy=%b done=%b err=%0d ffval=%b required all 0",
               x0, busy0, done0, err0, ffval0);
    end
    mode0 = 0;
    run_sweep(0, bc, da, sq);
    tests++;
    if (pass0 !== 1'b1 || da != 33) begin
      fails++; $display("FAIL reset_mid_resweep: got pass=%b done_at=%0d required 1 33", pass0, da);
    end
  endtask

  task automatic test_start_held;
    int da; bit sq;
    mode0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    da = -1; sq = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (c <= NV && int'(x0) != c - 1) sq = 1'b0;
      if (done0) begin da = c; break; end
      @(negedge clk);
    end
    tests++;
    if (da != 33 || !sq) begin
      fails++; $display("FAIL start_held_single: got done_at=%0d seq=%b required 33 1", da, sq);
    end
    @(negedge clk);
    start0 = 1'b0;
    tests++;
    if ({done0, busy0, x0} !== {1'b0, 1'b1, 5'd0}) begin
      fails++; $display("FAIL start_held_restart: got done=%b busy=%b x=%0d required 0 1 0", done0, busy0, x0);
    end
    for (int c = 0; c < 100 && !done0; c++) @(negedge clk);
  endtask

  task automatic test_restart_from_done;
    int bc, da; bit sq;
    mode0 = 2;
    run_sweep(0, bc, da, sq);
    mode0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tests++;
    if ({err0, ffval0, done0, busy0} !== {6'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL restart_clear: got err=%0d ffval=%b done=%b busy=%b required 0 0 0 1",
               err0, ffval0, done0, busy0);
    end
    for (int c = 0; c < 100 && !done0; c++) @(negedge clk);
    tests++;
    if (pass0 !== 1'b1) begin fails++; $display("FAIL restart_pass: got %b required 1", pass0); end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    test_reset();
    test_clean_sweep();
    test_single_fault();
    test_stuck();
    test_random_faults();
    test_latency();
    test_reset_mid();
    test_start_held();
    test_restart_from_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
